// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game blocks.
// Holds the game FSM state encoding, the difficulty encoding and the
// default millisecond timings used by the sequencer, display and timers.
package mole_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_MOLE_UP   = 3'd2,
    ST_GAP       = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    DIFF_EASY   = 2'b00,
    DIFF_MEDIUM = 2'b01,
    DIFF_HARD   = 2'b10
  } diff_e;

  // Width of the ms_remaining bus and of the game counters.
  localparam int MS_W  = 13;
  localparam int CNT_W = 8;

  // Default timings (ms) and game length.
  localparam int DEF_CLKS_PER_MS  = 50000;
  localparam int DEF_COUNTDOWN_MS = 3000;
  localparam int DEF_EASY_MS      = 2000;
  localparam int DEF_MEDIUM_MS    = 1000;
  localparam int DEF_HARD_MS      = 500;
  localparam int DEF_GAP_MS       = 250;
  localparam int DEF_ROUNDS       = 20;

endpackage

// File: rtl/mole_round_sequencer_if.sv
// Control/status bundle between the game front end (keys, switches,
// hammer) and the round sequencer.
//   master : front end - drives start, difficulty requests, hit
//   slave  : sequencer - drives mole/countdown/game-over status and counters
interface mole_round_sequencer_if;
  import mole_game_pkg::*;

  logic                  start;
  logic                  diff_easy;
  logic                  diff_medium;
  logic                  diff_hard;
  logic                  hit;
  logic                  new_mole;
  logic                  mole_active;
  logic                  countdown_active;
  logic                  game_over;
  logic [1:0]            difficulty;
  logic [CNT_W-1:0]      round;
  logic [CNT_W-1:0]      score;
  logic [CNT_W-1:0]      misses;
  logic [MS_W-1:0]       ms_remaining;

  modport master (
    output start, diff_easy, diff_medium, diff_hard, hit,
    input  new_mole, mole_active, countdown_active, game_over,
           difficulty, round, score, misses, ms_remaining
  );

  modport slave (
    input  start, diff_easy, diff_medium, diff_hard, hit,
    output new_mole, mole_active, countdown_active, game_over,
           difficulty, round, score, misses, ms_remaining
  );
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts CLKS_PER_MS cycles and flags the last one.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : synchronous clear, counter restarts at 0 next cycle
//   tick_o     : high for one cycle every CLKS_PER_MS cycles
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  localparam int            CW   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mole_round_sequencer.sv
// Game-level FSM for whack-a-mole: difficulty latch, countdown, ROUNDS
// mole/gap rounds, hit/miss counting, game over.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mole_round_sequencer_if (inputs start,
//                diff_*, hit; registered status and counter outputs)
module mole_round_sequencer
  import mole_game_pkg::*;
#(
  parameter int CLKS_PER_MS  = DEF_CLKS_PER_MS,
  parameter int COUNTDOWN_MS = DEF_COUNTDOWN_MS,
  parameter int EASY_MS      = DEF_EASY_MS,
  parameter int MEDIUM_MS    = DEF_MEDIUM_MS,
  parameter int HARD_MS      = DEF_HARD_MS,
  parameter int GAP_MS       = DEF_GAP_MS,
  parameter int ROUNDS       = DEF_ROUNDS
) (
  input  logic                  clk,
  input  logic                  reset,
  mole_round_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(ROUNDS);

  state_e           state_q, state_d;
  logic [1:0]       diff_q, diff_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] score_q, score_d;
  logic [CNT_W-1:0] misses_q, misses_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic             start_q;
  logic             new_mole_q, mole_q, cd_q, go_q;
  logic             tick, expire, start_edge, enter;

  // Phase length in ms for the state being entered; 0 for untimed states.
  function automatic logic [MS_W-1:0] phase_len(state_e s, logic [1:0] d);
    logic [MS_W-1:0] len;
    len = '0;
    case (s)
      ST_COUNTDOWN: len = MS_W'(COUNTDOWN_MS);
      ST_GAP:       len = MS_W'(GAP_MS);
      ST_MOLE_UP: begin
        case (d)
          DIFF_HARD:   len = MS_W'(HARD_MS);
          DIFF_MEDIUM: len = MS_W'(MEDIUM_MS);
          default:     len = MS_W'(EASY_MS);
        endcase
      end
      default:      len = '0;
    endcase
    return len;
  endfunction

  assign start_edge = bus.start & ~start_q;
  // The tick that would take ms_remaining 1 -> 0 ends the phase instead,
  // so a phase of N ms lasts exactly N*CLKS_PER_MS cycles.
  assign expire     = tick && (ms_q == MS_W'(1));
  assign enter      = (state_d != state_q);

  // Prescaler restarts on every state change so each phase starts aligned.
  ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (enter),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    diff_d   = diff_q;
    round_d  = round_q;
    score_d  = score_q;
    misses_d = misses_q;
    ms_d     = ms_q;

    case (state_q)
      ST_IDLE: begin
        if      (bus.diff_hard)   diff_d = DIFF_HARD;
        else if (bus.diff_medium) diff_d = DIFF_MEDIUM;
        else if (bus.diff_easy)   diff_d = DIFF_EASY;
        if (start_edge) begin
          state_d  = ST_COUNTDOWN;
          round_d  = '0;
          score_d  = '0;
          misses_d = '0;
        end
      end
      ST_COUNTDOWN: begin
        if (expire) begin
          state_d = ST_MOLE_UP;
          round_d = round_q + 1'b1;
        end
      end
      ST_MOLE_UP: begin
        // A hit in the expiry cycle still counts as a hit.
        if (bus.hit) begin
          state_d = ST_GAP;
          score_d = score_q + 1'b1;
        end else if (expire) begin
          state_d  = ST_GAP;
          misses_d = misses_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (expire) begin
          if (round_q == ROUNDS_C) begin
            state_d = ST_GAME_OVER;
          end else begin
            state_d = ST_MOLE_UP;
            round_d = round_q + 1'b1;
          end
        end
      end
      ST_GAME_OVER: begin
        if (start_edge) begin
          state_d  = ST_COUNTDOWN;
          round_d  = '0;
          score_d  = '0;
          misses_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Difficulty only changes in IDLE, so diff_q is stable at mole entry.
    if (enter)                     ms_d = phase_len(state_d, diff_q);
    else if (tick && ms_q != '0)   ms_d = ms_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      diff_q     <= DIFF_EASY;
      round_q    <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      ms_q       <= '0;
      start_q    <= 1'b0;
      new_mole_q <= 1'b0;
      mole_q     <= 1'b0;
      cd_q       <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      diff_q     <= diff_d;
      round_q    <= round_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      ms_q       <= ms_d;
      start_q    <= bus.start;
      new_mole_q <= (state_d == ST_MOLE_UP) && (state_q != ST_MOLE_UP);
      mole_q     <= (state_d == ST_MOLE_UP);
      cd_q       <= (state_d == ST_COUNTDOWN);
      go_q       <= (state_d == ST_GAME_OVER);
    end
  end

  assign bus.new_mole         = new_mole_q;
  assign bus.mole_active      = mole_q;
  assign bus.countdown_active = cd_q;
  assign bus.game_over        = go_q;
  assign bus.difficulty       = diff_q;
  assign bus.round            = round_q;
  assign bus.score            = score_q;
  assign bus.misses           = misses_q;
  assign bus.ms_remaining     = ms_q;
endmodule

// File: tb/tb_mole_round_sequencer.sv
module tb_mole_round_sequencer;
  import mole_game_pkg::*;

  localparam int CPM = 4, CD = 3, EZ = 5, MD = 3, HD = 2, GP = 1, RN = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mole_round_sequencer_if bus();

  mole_round_sequencer #(
    .CLKS_PER_MS(CPM), .COUNTDOWN_MS(CD), .EASY_MS(EZ), .MEDIUM_MS(MD),
    .HARD_MS(HD), .GAP_MS(GP), .ROUNDS(RN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int round;
    int score;
    int misses;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mdl_round = 0, mdl_score = 0, mdl_misses = 0;
  bit   mon_prev = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard consumer: at the end of every mole, compare counters with
  // the outcome the stimulus queued for that mole.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mon_prev = 1'b0;
    end else begin
      if (mon_prev && !bus.mole_active) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_round", int'(bus.round), e.round);
          chk("sb_score", int'(bus.score), e.score);
          chk("sb_misses", int'(bus.misses), e.misses);
        end
      end
      mon_prev = bus.mole_active;
    end
  end

  task automatic run_countdown();
    int n = 0;
    chk("cd_ms_load", int'(bus.ms_remaining), CD);
    while (bus.countdown_active && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("cd_len", n, CD * CPM);
  endtask

  // Entered on the first cycle of a mole; leaves on the first GAP cycle.
  task automatic run_mole(input int len, input int hit_k, input bit poke_start, input int ms_ld);
    int   n = 0;
    exp_t e;
    chk("mole_new", int'(bus.new_mole), 1);
    chk("mole_up", int'(bus.mole_active), 1);
    mdl_round++;
    chk("mole_round", int'(bus.round), mdl_round);
    chk("mole_ms", int'(bus.ms_remaining), ms_ld);
    if (hit_k >= 0) mdl_score++;
    else            mdl_misses++;
    e.round = mdl_round; e.score = mdl_score; e.misses = mdl_misses;
    sb.push_back(e);
    while (bus.mole_active && n < 50) begin
      bus.hit = (n == hit_k);
      if (poke_start) bus.start = (n == 1 || n == 2);
      n++;
      @(negedge clk);
      bus.hit = 1'b0;
      if (n == 1) chk("new_mole_1cyc", int'(bus.new_mole), 0);
    end
    bus.start = 1'b0;
    chk("mole_len", n, (hit_k >= 0) ? hit_k + 1 : len);
    chk("gap_ms", int'(bus.ms_remaining), GP);
    chk("mole_no_cd", int'(bus.countdown_active), 0);
  endtask

  task automatic run_gap(input int exp_len);
    int n = 0;
    while (!bus.mole_active && !bus.game_over && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("gap_len", n, exp_len);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_new"},   int'(bus.new_mole), 0);
    chk({tag, "_mole"},  int'(bus.mole_active), 0);
    chk({tag, "_cd"},    int'(bus.countdown_active), 0);
    chk({tag, "_go"},    int'(bus.game_over), 0);
    chk({tag, "_diff"},  int'(bus.difficulty), 0);
    chk({tag, "_round"}, int'(bus.round), 0);
    chk({tag, "_score"}, int'(bus.score), 0);
    chk({tag, "_miss"},  int'(bus.misses), 0);
    chk({tag, "_ms"},    int'(bus.ms_remaining), 0);
  endtask

  initial begin
    bus.start = 0; bus.diff_easy = 0; bus.diff_medium = 0;
    bus.diff_hard = 0; bus.hit = 0;

    // Reset for two cycles
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Game 1: hard
    bus.diff_hard = 1'b1; @(negedge clk); bus.diff_hard = 1'b0; @(negedge clk);
    chk("diff_hard", int'(bus.difficulty), 2);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    chk("cd_on", int'(bus.countdown_active), 1);
    run_countdown();
    run_mole(HD * CPM, -1, 1'b0, HD);
    run_gap(GP * CPM);
    run_mole(HD * CPM, HD * CPM - 1, 1'b0, HD);   // hit in the expiry cycle
    chk("exp_hit_miss", int'(bus.misses), 1);
    run_gap(GP * CPM);
    run_mole(HD * CPM, -1, 1'b1, HD);             // start poked mid-mole
    run_gap(GP * CPM);
    chk("go_on", int'(bus.game_over), 1);
    chk("go_round", int'(bus.round), RN);
    chk("go_total", int'(bus.score) + int'(bus.misses), RN);
    chk("go_score", int'(bus.score), 1);
    chk("go_ms", int'(bus.ms_remaining), 0);
    repeat (3) @(negedge clk);
    chk("go_hold", int'(bus.game_over), 1);
    chk("go_hold_round", int'(bus.round), RN);

    // Restart from GAME_OVER
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    chk("re_cd", int'(bus.countdown_active), 1);
    chk("re_go", int'(bus.game_over), 0);
    chk("re_round", int'(bus.round), 0);
    chk("re_score", int'(bus.score), 0);
    chk("re_miss", int'(bus.misses), 0);
    mdl_round = 0; mdl_score = 0; mdl_misses = 0;
    run_countdown();
    chk("g2_new", int'(bus.new_mole), 1);
    chk("g2_round", int'(bus.round), 1);

    // Reset in the middle of a mole
    repeat (3) @(negedge clk);
    reset = 1'b1; @(negedge clk);
    chk_all_zero("midrst");
    reset = 1'b0;
    bus.hit = 1'b1; @(negedge clk); bus.hit = 1'b0; @(negedge clk);
    chk("stray_hit_score", int'(bus.score), 0);
    chk("stray_hit_mole", int'(bus.mole_active), 0);

    // Game 2: medium wins over easy
    bus.diff_medium = 1'b1; bus.diff_easy = 1'b1; @(negedge clk);
    bus.diff_medium = 1'b0; bus.diff_easy = 1'b0; @(negedge clk);
    chk("diff_med", int'(bus.difficulty), 1);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    run_countdown();
    run_mole(MD * CPM, 2, 1'b0, MD);
    chk("hit_score", int'(bus.score), 1);
    chk("hit_mole_off", int'(bus.mole_active), 0);
    bus.diff_hard = 1'b1; @(negedge clk); bus.diff_hard = 1'b0;
    run_gap(GP * CPM - 1);
    chk("diff_locked", int'(bus.difficulty), 1);
    run_mole(MD * CPM, -1, 1'b0, MD);
    run_gap(GP * CPM);
    run_mole(MD * CPM, -1, 1'b0, MD);
    run_gap(GP * CPM);
    chk("go2_on", int'(bus.game_over), 1);
    chk("go2_score", int'(bus.score), 1);
    chk("go2_miss", int'(bus.misses), 2);
    @(negedge clk);
    chk("sb_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
